sd_resp_rx: RTL

Host-side SD CMD-line response receiver: the counterpart of the command-issuing FSM. After the FSM sends a command, it arms this block. The block hunts for the card's start bit within the N_CR window and deserializes a 48-bit (R1/R1b/R3/R6/R7) or 136-bit (R2) response. It checks CRC7 and framing, then hands the index, argument and long payload back to the FSM with a single done pulse.

---
 rtl/sd_pkg.sv | 24 ++
 rtl/sd_resp_rx_if.sv | 31 +++
 rtl/sd_crc7.sv | 38 +++
 rtl/sd_resp_rx.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared SD host definitions: CRC7 polynomial, response frame lengths,
// default N_CR window and the response receiver state encoding.
package sd_pkg;

    localparam logic [6:0] CRC7_POLY       = 7'h09;
    localparam logic [7:0] FRAME_LEN_SHORT = 8'd48;
    localparam logic [7:0] FRAME_LEN_LONG  = 8'd136;
    localparam int         N_CR_DEFAULT    = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_RX,
        ST_DONE
    } rx_state_e;

    // One serial step of x^7 + x^3 + 1, MSB-first.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_resp_rx_if.sv
// CMD-line response receiver handshake bundle between the command FSM
// (master) and the receiver (slave).
interface sd_resp_rx_if;

    logic         bit_en;
    logic         cmd_in;
    logic         start;
    logic         long_resp;
    logic         check_crc;
    logic         busy;
    logic         done;
    logic         timeout;
    logic         crc_err;
    logic         frame_err;
    logic [5:0]   resp_index;
    logic [31:0]  resp_arg;
    logic [127:0] resp_data;

    modport master (
        output bit_en, cmd_in, start, long_resp, check_crc,
        input  busy, done, timeout, crc_err, frame_err,
        input  resp_index, resp_arg, resp_data
    );

    modport slave (
        input  bit_en, cmd_in, start, long_resp, check_crc,
        output busy, done, timeout, crc_err, frame_err,
        output resp_index, resp_arg, resp_data
    );

endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 generator, zero init. clr together with en restarts the
// checksum and feeds din as the first bit.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;
    logic [6:0] crcBase;

    always_comb begin
        crcBase = clr ? 7'h00 : crc_q;
        crc_d   = crc_q;
        if (en) begin
            crc_d = crc7_step(crcBase, din);
        end else if (clr) begin
            crc_d = 7'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= 7'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_resp_rx.sv
// Host-side SD CMD response receiver: hunts for the start bit within N_CR,
// deserializes 48/136-bit responses and reports CRC7/framing/timeout status.
module sd_resp_rx
    import sd_pkg::*;
#(
    parameter int TIMEOUT_BITS = N_CR_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    sd_resp_rx_if.slave  bus
);

    localparam int             TW       = $clog2(TIMEOUT_BITS + 1);
    localparam logic [TW-1:0]  TO_LIMIT = TW'(TIMEOUT_BITS);

    rx_state_e      state_q, state_d;
    logic [7:0]     bitCnt_q, bitCnt_d;
    logic [TW-1:0]  toCnt_q, toCnt_d;
    logic           longResp_q, longResp_d;
    logic           checkCrc_q, checkCrc_d;
    logic [133:0]   shift_q, shift_d;
    logic           timeout_q, timeout_d;
    logic           crcErr_q, crcErr_d;
    logic           frameErr_q, frameErr_d;
    logic [5:0]     respIndex_q, respIndex_d;
    logic [31:0]    respArg_q, respArg_d;
    logic [127:0]   respData_q, respData_d;

    logic [7:0]     lastBit;
    logic           crcClr;
    logic           crcEn;
    logic [6:0]     crcVal;

    sd_crc7 u_crc (
        .clk   (clk),
        .reset (reset),
        .clr   (crcClr),
        .en    (crcEn),
        .din   (bus.cmd_in),
        .crc   (crcVal)
    );

    // The start bit is never stored, so on the end-bit strobe frame bit i
    // (i >= 1) sits in shift_q[i-1] and the end bit is still on cmd_in.
    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        toCnt_d     = toCnt_q;
        longResp_d  = longResp_q;
        checkCrc_d  = checkCrc_q;
        shift_d     = shift_q;
        timeout_d   = timeout_q;
        crcErr_d    = crcErr_q;
        frameErr_d  = frameErr_q;
        respIndex_d = respIndex_q;
        respArg_d   = respArg_q;
        respData_d  = respData_q;
        crcClr      = 1'b0;
        crcEn       = 1'b0;
        lastBit     = longResp_q ? (FRAME_LEN_LONG - 8'd1) : (FRAME_LEN_SHORT - 8'd1);

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    longResp_d  = bus.long_resp;
                    checkCrc_d  = bus.check_crc;
                    timeout_d   = 1'b0;
                    crcErr_d    = 1'b0;
                    frameErr_d  = 1'b0;
                    respIndex_d = '0;
                    respArg_d   = '0;
                    respData_d  = '0;
                    bitCnt_d    = '0;
                    toCnt_d     = '0;
                    state_d     = ST_WAIT_START;
                end
            end
            ST_WAIT_START: begin
                if (bus.bit_en) begin
                    if (!bus.cmd_in) begin
                        crcClr   = 1'b1;
                        crcEn    = 1'b1;
                        bitCnt_d = 8'd1;
                        state_d  = ST_RX;
                    end else begin
                        toCnt_d = toCnt_q + 1'b1;
                        if (toCnt_d == TO_LIMIT) begin
                            timeout_d = 1'b1;
                            state_d   = ST_DONE;
                        end
                    end
                end
            end
            ST_RX: begin
                if (bus.bit_en) begin
                    shift_d  = {shift_q[132:0], bus.cmd_in};
                    bitCnt_d = bitCnt_q + 8'd1;
                    // R2 excludes tx and reserved bits: restart CRC just before bit 127.
                    if (longResp_q) begin
                        crcClr = (bitCnt_q == 8'd7);
                        crcEn  = (bitCnt_q >= 8'd8) && (bitCnt_q < 8'd128);
                    end else begin
                        crcEn  = (bitCnt_q < 8'd40);
                    end
                    if (bitCnt_q == lastBit) begin
                        state_d  = ST_DONE;
                        crcErr_d = checkCrc_q && (crcVal != shift_q[6:0]);
                        if (longResp_q) begin
                            frameErr_d  = shift_q[133] || (shift_q[132:127] != 6'h3F) || !bus.cmd_in;
                            respIndex_d = shift_q[132:127];
                            respArg_d   = '0;
                            respData_d  = {shift_q[126:0], 1'b0};
                        end else begin
                            frameErr_d  = shift_q[45] || !bus.cmd_in;
                            respIndex_d = shift_q[44:39];
                            respArg_d   = shift_q[38:7];
                            respData_d  = '0;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bitCnt_q    <= '0;
            toCnt_q     <= '0;
            longResp_q  <= 1'b0;
            checkCrc_q  <= 1'b0;
            shift_q     <= '0;
            timeout_q   <= 1'b0;
            crcErr_q    <= 1'b0;
            frameErr_q  <= 1'b0;
            respIndex_q <= '0;
            respArg_q   <= '0;
            respData_q  <= '0;
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            toCnt_q     <= toCnt_d;
            longResp_q  <= longResp_d;
            checkCrc_q  <= checkCrc_d;
            shift_q     <= shift_d;
            timeout_q   <= timeout_d;
            crcErr_q    <= crcErr_d;
            frameErr_q  <= frameErr_d;
            respIndex_q <= respIndex_d;
            respArg_q   <= respArg_d;
            respData_q  <= respData_d;
        end
    end

    assign bus.busy       = (state_q == ST_WAIT_START) || (state_q == ST_RX);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.timeout    = timeout_q;
    assign bus.crc_err    = crcErr_q;
    assign bus.frame_err  = frameErr_q;
    assign bus.resp_index = respIndex_q;
    assign bus.resp_arg   = respArg_q;
    assign bus.resp_data  = respData_q;

endmodule
